l2_access_arbiter: RTL and testbench

//  Shares the single L2 lookup/update engine among NUM_CORES L1 miss requesters.

---
 rtl/l2_arb_pkg.sv | 24 ++
 rtl/l2_access_arbiter_if.sv | 46 ++++
 rtl/rr_priority_picker.sv | 34 +++
 rtl/l2_access_arbiter.sv | 165 ++++++++++++++++
 tb/tb_l2_access_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_arb_pkg.sv
// Shared types and default sizing for the L2 access arbiter.
// Optional per-core statistics are enabled with the L2_ARB_STATS_EN macro.
package l2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam int DEF_NUM_CORES          = 4;
    localparam int DEF_SET_INDEX          = 6;
    localparam int DEF_BLOCK_OFFSET_INDEX = 4;
    localparam int DEF_WAY_WIDTH          = 4;
    localparam int DEF_TAG_WIDTH          = 32 - DEF_SET_INDEX - DEF_BLOCK_OFFSET_INDEX;
    localparam int DEF_TIMEOUT_CYCLES     = 1024;

    // hit_way value the L2 reports for a miss (one past the last real way)
    localparam int MISS_WAY = 2 ** DEF_WAY_WIDTH;

    localparam int STATS_W = 20;

endpackage

// File: rtl/l2_access_arbiter_if.sv
// Bundle of core-side request/ack signals and L2-side operand/result signals.
// master = arbiter view, slave = cores plus L2 view.
interface l2_access_arbiter_if
    import l2_arb_pkg::*;
#(
    parameter int NUM_CORES          = DEF_NUM_CORES,
    parameter int SET_INDEX          = DEF_SET_INDEX,
    parameter int BLOCK_OFFSET_INDEX = DEF_BLOCK_OFFSET_INDEX,
    parameter int WAY_WIDTH          = DEF_WAY_WIDTH,
    parameter int TAG_WIDTH          = 32 - SET_INDEX - BLOCK_OFFSET_INDEX
);
    logic [NUM_CORES-1:0]                    req;
    logic [NUM_CORES*TAG_WIDTH-1:0]          req_tag;
    logic [NUM_CORES*SET_INDEX-1:0]          req_index;
    logic [NUM_CORES*BLOCK_OFFSET_INDEX-1:0] req_offset;
    logic [NUM_CORES-1:0]                    req_ins_type;
    logic [NUM_CORES-1:0]                    ack;
    logic                                    resp_hit;
    logic [WAY_WIDTH:0]                      resp_way;
    logic                                    busy;
    logic                                    err_timeout;

    logic                                    l2_find_start;
    logic [TAG_WIDTH-1:0]                    l2_tag;
    logic [SET_INDEX-1:0]                    l2_index;
    logic [BLOCK_OFFSET_INDEX-1:0]           l2_block_offset;
    logic                                    l2_ins_type;
    logic                                    l2_found;
    logic [WAY_WIDTH:0]                      l2_hit_way;
    logic                                    l2_updated;

    modport master (
        input  req, req_tag, req_index, req_offset, req_ins_type,
        output ack, resp_hit, resp_way, busy, err_timeout,
        output l2_find_start, l2_tag, l2_index, l2_block_offset, l2_ins_type,
        input  l2_found, l2_hit_way, l2_updated
    );

    modport slave (
        output req, req_tag, req_index, req_offset, req_ins_type,
        input  ack, resp_hit, resp_way, busy, err_timeout,
        input  l2_find_start, l2_tag, l2_index, l2_block_offset, l2_ins_type,
        output l2_found, l2_hit_way, l2_updated
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin select: first asserted request at or after rr_ptr_i,
// returned both as a onehot vector and as an index.
module rr_priority_picker #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] rr_ptr_i,
    output logic [N-1:0]     grant_oh_o,
    output logic [PTR_W-1:0] grant_idx_o
);

    always_comb begin
        int               idx;
        logic [PTR_W-1:0] sel;
        // NOTE: every output gets a default before the loop so no path leaves a latch.
        grant_oh_o  = '0;
        grant_idx_o = '0;
        idx         = 0;
        sel         = '0;
        // Walk from farthest to nearest so the candidate closest to rr_ptr_i wins.
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_i) + k;
            if (idx >= N) idx = idx - N;
            sel = PTR_W'(idx);
            if (req_i[sel]) begin
                grant_oh_o      = '0;
                grant_oh_o[sel] = 1'b1;
                grant_idx_o     = sel;
            end
        end
    end

endmodule

// File: rtl/l2_access_arbiter.sv
// Round-robin arbiter sharing one L2 lookup/update engine among NUM_CORES L1 miss paths.
// Defining L2_ARB_STATS_EN adds saturating per-core grant_count/hit_count outputs.
module l2_access_arbiter
    import l2_arb_pkg::*;
#(
    parameter int NUM_CORES          = DEF_NUM_CORES,
    parameter int SET_INDEX          = DEF_SET_INDEX,
    parameter int BLOCK_OFFSET_INDEX = DEF_BLOCK_OFFSET_INDEX,
    parameter int WAY_WIDTH          = DEF_WAY_WIDTH,
    parameter int TAG_WIDTH          = 32 - SET_INDEX - BLOCK_OFFSET_INDEX,
    parameter int TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           reset,
    l2_access_arbiter_if.master            bus
`ifdef L2_ARB_STATS_EN
    ,
    output logic [NUM_CORES*STATS_W-1:0]   grant_count,
    output logic [NUM_CORES*STATS_W-1:0]   hit_count
`endif
);

    localparam int                 PTR_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int                 CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W-1:0]   LAST    = PTR_W'(NUM_CORES - 1);
    localparam logic [WAY_WIDTH:0] MISS    = {1'b1, {WAY_WIDTH{1'b0}}};

    arb_state_e                    state_q, state_d;
    logic [PTR_W-1:0]              rr_ptr_q;
    logic [PTR_W-1:0]              grant_idx_q, pick_idx;
    logic [NUM_CORES-1:0]          grant_oh_q, pick_oh;
    logic [TAG_WIDTH-1:0]          tag_q;
    logic [SET_INDEX-1:0]          index_q;
    logic [BLOCK_OFFSET_INDEX-1:0] offset_q;
    logic                          ins_q;
    logic                          resp_hit_q;
    logic [WAY_WIDTH:0]            resp_way_q;
    logic                          err_q;
    logic [CNT_W-1:0]              cnt_q;

    logic latch_en, cnt_clr, cnt_inc, capture_en, timeout_en, rr_adv;

    rr_priority_picker #(
        .N     (NUM_CORES),
        .PTR_W (PTR_W)
    ) u_picker (
        .req_i       (bus.req),
        .rr_ptr_i    (rr_ptr_q),
        .grant_oh_o  (pick_oh),
        .grant_idx_o (pick_idx)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        latch_en   = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        capture_en = 1'b0;
        timeout_en = 1'b0;
        rr_adv     = 1'b0;
        case (state_q)
            IDLE: if (|bus.req) begin
                latch_en = 1'b1;
                state_d  = ISSUE;
            end
            ISSUE: begin
                cnt_clr = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.l2_updated) begin
                    capture_en = 1'b1;
                    state_d    = RESP;
                end else if (cnt_q == CNT_MAX) begin
                    timeout_en = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RESP: begin
                rr_adv  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            grant_oh_q  <= '0;
            tag_q       <= '0;
            index_q     <= '0;
            offset_q    <= '0;
            ins_q       <= 1'b0;
            resp_hit_q  <= 1'b0;
            resp_way_q  <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (latch_en) begin
                grant_idx_q <= pick_idx;
                grant_oh_q  <= pick_oh;
                tag_q       <= bus.req_tag[int'(pick_idx)*TAG_WIDTH +: TAG_WIDTH];
                index_q     <= bus.req_index[int'(pick_idx)*SET_INDEX +: SET_INDEX];
                offset_q    <= bus.req_offset[int'(pick_idx)*BLOCK_OFFSET_INDEX +: BLOCK_OFFSET_INDEX];
                ins_q       <= bus.req_ins_type[pick_idx];
            end
            if (cnt_clr)      cnt_q <= '0;
            else if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
            if (capture_en) begin
                resp_hit_q <= bus.l2_found;
                resp_way_q <= bus.l2_hit_way;
            end
            if (timeout_en) begin
                resp_hit_q <= 1'b0;
                resp_way_q <= MISS;
                err_q      <= 1'b1;
            end
            if (rr_adv) rr_ptr_q <= (grant_idx_q == LAST) ? '0 : grant_idx_q + PTR_W'(1);
        end
    end

    assign bus.l2_find_start   = (state_q == ISSUE);
    assign bus.ack             = (state_q == RESP) ? grant_oh_q : '0;
    assign bus.busy            = (state_q != IDLE);
    assign bus.resp_hit        = resp_hit_q;
    assign bus.resp_way        = resp_way_q;
    assign bus.err_timeout     = err_q;
    assign bus.l2_tag          = tag_q;
    assign bus.l2_index        = index_q;
    assign bus.l2_block_offset = offset_q;
    assign bus.l2_ins_type     = ins_q;

`ifdef L2_ARB_STATS_EN
    localparam logic [STATS_W-1:0] STATS_MAX = {STATS_W{1'b1}};

    logic [NUM_CORES-1:0][STATS_W-1:0] grant_cnt_q, hit_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt_q <= '0;
            hit_cnt_q   <= '0;
        end else if (state_q == RESP) begin
            if (grant_cnt_q[grant_idx_q] != STATS_MAX)
                grant_cnt_q[grant_idx_q] <= grant_cnt_q[grant_idx_q] + STATS_W'(1);
            if (resp_hit_q && hit_cnt_q[grant_idx_q] != STATS_MAX)
                hit_cnt_q[grant_idx_q] <= hit_cnt_q[grant_idx_q] + STATS_W'(1);
        end
    end

    assign grant_count = grant_cnt_q;
    assign hit_count   = hit_cnt_q;
`endif

endmodule

// File: tb/tb_l2_access_arbiter.sv
// Directed bench for l2_access_arbiter: L2 stub, ack scoreboard, find_start spacing monitor.
// Compile with L2_ARB_STATS_EN to also exercise the statistics counters.
module tb_l2_access_arbiter;
    import l2_arb_pkg::*;

    localparam int NC = DEF_NUM_CORES;
    localparam int TW = DEF_TAG_WIDTH;
    localparam int SW = DEF_SET_INDEX;
    localparam int OW = DEF_BLOCK_OFFSET_INDEX;

    typedef struct {
        int              core;
        logic            hit;
        logic [4:0]      way;
        logic [TW-1:0]   tag;
        logic [SW-1:0]   index;
        logic            ins;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    l2_access_arbiter_if bus ();

`ifdef L2_ARB_STATS_EN
    logic [NC*STATS_W-1:0] grant_count, hit_count;
`endif

    l2_access_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus)
`ifdef L2_ARB_STATS_EN
        ,
        .grant_count (grant_count),
        .hit_count   (hit_count)
`endif
    );

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    exp_t sb[$];

    int   cycle   = 0;
    int   fs_count = 0;
    int   last_fs = -1;

    int         stub_delay = 1;
    logic       stub_hit   = 1'b0;
    logic [4:0] stub_way   = '0;
    bit         stub_never = 1'b0;
    bit         stub_from_tag = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic drive_req(input int core, input logic [TW-1:0] tag, input logic [SW-1:0] idx,
                             input logic [OW-1:0] off, input logic ins);
        bus.req_tag[core*TW +: TW]    = tag;
        bus.req_index[core*SW +: SW]  = idx;
        bus.req_offset[core*OW +: OW] = off;
        bus.req_ins_type[core]        = ins;
        bus.req[core]                 = 1'b1;
    endtask

    task automatic push(input int core, input logic hit, input logic [4:0] way,
                        input logic [TW-1:0] tag, input logic [SW-1:0] idx, input logic ins);
        exp_t e;
        e.core = core; e.hit = hit; e.way = way; e.tag = tag; e.index = idx; e.ins = ins;
        sb.push_back(e);
    endtask

    // Returns at posedge+1 of the cycle after the last expected ack.
    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, sb.size(), 0);
    endtask

    task automatic wait_fs(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.l2_find_start && n < budget);
        check(tag, bus.l2_find_start, 1);
    endtask

    always @(posedge clk) cycle++;

    // Scoreboard and find_start spacing monitor
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (bus.ack !== '0) begin
                check("ack_onehot", $onehot(bus.ack), 1);
                if (sb.size() == 0) begin
                    check("ack_unexpected", bus.ack, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ack_core", bus.ack, 4'b1 << e.core);
                    check("resp_hit", bus.resp_hit, e.hit);
                    check("resp_way", bus.resp_way, e.way);
                    check("l2_tag_held", bus.l2_tag, e.tag);
                    check("l2_index_held", bus.l2_index, e.index);
                    check("l2_ins_held", bus.l2_ins_type, e.ins);
                end
            end
            if (bus.l2_find_start === 1'b1) begin
                if (last_fs >= 0) check("fs_gap_ge2", (cycle - last_fs) >= 2, 1);
                last_fs = cycle;
                fs_count++;
            end
        end
    end

    // L2 stub: answers each find_start after stub_delay cycles unless stub_never
    initial begin
        bus.l2_found   = 1'b0;
        bus.l2_hit_way = '0;
        bus.l2_updated = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && bus.l2_find_start === 1'b1 && !stub_never) begin
                repeat (stub_delay) @(negedge clk);
                bus.l2_found   = stub_hit;
                bus.l2_hit_way = stub_from_tag ? {1'b0, bus.l2_tag[3:0]} : stub_way;
                bus.l2_updated = 1'b1;
                @(negedge clk);
                bus.l2_updated = 1'b0;
                bus.l2_found   = 1'b0;
                bus.l2_hit_way = '0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset            = 1'b0;
        bus.req          = '0;
        bus.req_tag      = '0;
        bus.req_index    = '0;
        bus.req_offset   = '0;
        bus.req_ins_type = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", bus.ack, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_find_start", bus.l2_find_start, 0);
        check("rst_err", bus.err_timeout, 0);
        check("rst_resp_way", bus.resp_way, 0);
        check("rst_l2_tag", bus.l2_tag, 0);
        @(negedge clk) reset = 1'b1;

        // 1: single load on core 0, hit way 2 after 5 cycles
        stub_delay = 5; stub_hit = 1'b1; stub_way = 5'd2; stub_from_tag = 1'b0;
        base = fs_count;
        @(posedge clk); #1;
        drive_req(0, 22'h1234, 6'h15, 4'h3, 1'b0);
        push(0, 1'b1, 5'd2, 22'h1234, 6'h15, 1'b0);
        wait_drain("t1_drain", 100);
        bus.req[0] = 1'b0;
        check("t1_fs_count", fs_count - base, 1);

        // 2: all four cores held after a fresh reset -> 0,1,2,3,0
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        stub_delay = 1; stub_hit = 1'b1; stub_from_tag = 1'b1;
        base = fs_count;
        for (int i = 0; i < NC; i++) drive_req(i, TW'(22'h100 + i), SW'(i), OW'(i), 1'b0);
        for (int i = 0; i < 5; i++) begin
            int c;
            c = i % NC;
            push(c, 1'b1, 5'(c), TW'(22'h100 + c), SW'(c), 1'b0);
        end
        wait_drain("t2_drain", 200);
        bus.req = '0;
        check("t2_fs_count", fs_count - base, 5);

        // 3: store miss on core 2; req and tag change mid-flight must be ignored
        stub_delay = 8; stub_hit = 1'b0; stub_way = 5'd16; stub_from_tag = 1'b0;
        @(posedge clk); #1;
        drive_req(2, 22'h2BEEF, 6'h2A, 4'hF, 1'b1);
        push(2, 1'b0, 5'(MISS_WAY), 22'h2BEEF, 6'h2A, 1'b1);
        wait_fs("t3_fs", 50);
        repeat (3) @(negedge clk);
        check("t3_ins_wait", bus.l2_ins_type, 1);
        check("t3_busy", bus.busy, 1);
        bus.req[2] = 1'b0;
        bus.req_tag[2*TW +: TW] = '0;
        wait_drain("t3_drain", 50);

        // 4: L2 never answers -> timeout after 1024 WAIT cycles, then core 0 still served
        stub_never = 1'b1;
        @(posedge clk); #1;
        drive_req(3, 22'h3A5A5, 6'h01, 4'h0, 1'b0);
        push(3, 1'b0, 5'(MISS_WAY), 22'h3A5A5, 6'h01, 1'b0);
        wait_fs("t4_fs", 50);
        repeat (1024) @(negedge clk);
        check("t4_err_before", bus.err_timeout, 0);
        check("t4_busy_wait", bus.busy, 1);
        @(negedge clk);
        check("t4_err_set", bus.err_timeout, 1);
        check("t4_ack", bus.ack, 4'b1000);
        @(posedge clk); #1;
        bus.req[3] = 1'b0;
        wait_drain("t4_drain", 5);
        stub_never = 1'b0; stub_delay = 3; stub_hit = 1'b1; stub_way = 5'd9;
        drive_req(0, 22'h00ABC, 6'h3F, 4'h7, 1'b0);
        push(0, 1'b1, 5'd9, 22'h00ABC, 6'h3F, 1'b0);
        wait_drain("t4_next_drain", 50);
        bus.req[0] = 1'b0;
        check("t4_err_sticky", bus.err_timeout, 1);

        // 5: reset during WAIT aborts with no ack; dropped core 1 is not served later
        stub_never = 1'b1;
        @(posedge clk); #1;
        drive_req(1, 22'h11111, 6'h11, 4'h1, 1'b0);
        wait_fs("t5_fs", 50);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        #1;
        check("t5_rst_ack", bus.ack, 0);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_find_start", bus.l2_find_start, 0);
        check("t5_rst_l2_tag", bus.l2_tag, 0);
        check("t5_rst_err", bus.err_timeout, 0);
        bus.req[1] = 1'b0;
        stub_never = 1'b0; stub_delay = 2; stub_hit = 1'b1; stub_from_tag = 1'b1;
        drive_req(3, 22'h33333, 6'h33, 4'h3, 1'b0);
        drive_req(2, 22'h22222, 6'h22, 4'h2, 1'b0);
        push(2, 1'b1, 5'd2, 22'h22222, 6'h22, 1'b0);
        push(3, 1'b1, 5'd3, 22'h33333, 6'h33, 1'b0);
        @(negedge clk) reset = 1'b1;
        wait_drain("t5_drain", 100);
        bus.req = '0;

`ifdef L2_ARB_STATS_EN
        // 6: three hits and two misses on core 1
        stub_from_tag = 1'b0; stub_delay = 2;
        for (int i = 0; i < 5; i++) begin
            stub_hit = (i < 3);
            stub_way = (i < 3) ? 5'd4 : 5'd16;
            @(posedge clk); #1;
            drive_req(1, TW'(22'h1000 + i), 6'h05, 4'h0, 1'b0);
            push(1, (i < 3), (i < 3) ? 5'd4 : 5'd16, TW'(22'h1000 + i), 6'h05, 1'b0);
            wait_drain("t6_drain", 50);
            bus.req[1] = 1'b0;
        end
        check("t6_grant_count1", grant_count[1*STATS_W +: STATS_W], 5);
        check("t6_hit_count1", hit_count[1*STATS_W +: STATS_W], 3);
        check("t6_grant_count2", grant_count[2*STATS_W +: STATS_W], 1);
        check("t6_hit_count0", hit_count[0*STATS_W +: STATS_W], 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("final_idle", bus.busy, 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
